// File: rtl/skew_buffer.sv
// Per-lane {valid, data} delay lines that feed a systolic array edge, either diagonally skewed
// (lane i delayed i+1 cycles) or aligned (every lane delayed N cycles).
module skew_buffer #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic            skew_en,
    input  logic            flush,
    output logic [N-1:0]    out_valid,
    output logic [N*DW-1:0] out_data,
    output logic            busy,
    output logic            drain_done
);

    // Lane i, stage N-1 is the output stage. Stages N-1-i..N-1 form the skew chain.
    // Stages 0..N-2-i are pad stages that only carry beats in aligned mode.
    logic [N-1:0][N-1:0]         valid_q, valid_d;
    logic [N-1:0][N-1:0][DW-1:0] data_q, data_d;
    logic                        mode_q;
    logic                        busy_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic          lane_v;
        logic [DW-1:0] lane_d;

        assign lane_v = in_valid;
        assign lane_d = in_valid ? in_data[i*DW +: DW] : '0;

        for (genvar s = 0; s < N; s++) begin : g_stage
            if (s == N - 1 - i && s == 0) begin : g_in
                assign valid_d[i][s] = lane_v;
                assign data_d[i][s]  = lane_d;
            end else if (s == N - 1 - i) begin : g_entry
                // Skew mode enters here directly; aligned mode arrives through the pads.
                assign valid_d[i][s] = mode_q ? lane_v : valid_q[i][s-1];
                assign data_d[i][s]  = mode_q ? lane_d : data_q[i][s-1];
            end else if (s == 0) begin : g_pad_head
                assign valid_d[i][s] = mode_q ? 1'b0 : lane_v;
                assign data_d[i][s]  = mode_q ? '0 : lane_d;
            end else begin : g_shift
                assign valid_d[i][s] = valid_q[i][s-1];
                assign data_d[i][s]  = data_q[i][s-1];
            end
        end

        assign out_valid[i]          = valid_q[i][N-1];
        assign out_data[i*DW +: DW]  = data_q[i][N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            mode_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (flush) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
            // Clearing busy_q on flush keeps a flush-induced empty from looking like a drain.
            busy_q <= busy & ~flush;
            if (!busy && !in_valid) begin
                mode_q <= skew_en;
            end
        end
    end

    assign busy       = |valid_q;
    assign drain_done = busy_q & ~busy;

endmodule

// File: tb/tb_skew_buffer.sv
// Directed bench for skew_buffer at N=8, DW=8: skew/aligned latency, streaming, bubbles,
// mode hold, flush and asynchronous reset.
module tb_skew_buffer;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam logic [63:0] WordA = 64'h0807060504030201;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [N*DW-1:0] in_data;
    logic            skew_en;
    logic            flush;
    logic [N-1:0]    out_valid;
    logic [N*DW-1:0] out_data;
    logic            busy;
    logic            drain_done;

    int total = 0;
    int bad   = 0;

    skew_buffer #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .skew_en    (skew_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .drain_done (drain_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        skew_en  = 1'b1;
        flush    = 1'b0;
        #3;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_out_valid got %h want 00", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain got %b want 0", drain_done); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_skew_single;
        logic [7:0]  ev;
        logic [63:0] ed;
        in_valid = 1'b1;
        in_data  = WordA;
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            ev = 8'(1 << (k - 1));
            ed = WordA & (64'hFF << ((k - 1) * 8));
            total++; if (out_valid !== ev) begin bad++; $display("FAIL skew1_valid k=%0d got %h want %h", k, out_valid, ev); end
            total++; if (out_data !== ed) begin bad++; $display("FAIL skew1_data k=%0d got %h want %h", k, out_data, ed); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL skew1_busy k=%0d got %b want 1", k, busy); end
            total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL skew1_drain k=%0d got %b want 0", k, drain_done); end
        end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL skew1_busy_end got %b want 0", busy); end
        total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL skew1_drain_pulse got %b want 1", drain_done); end
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL skew1_valid_end got %h want 00", out_valid); end
        tick();
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL skew1_drain_width got %b want 0", drain_done); end
    endtask

    // Expects mode_q already loaded to aligned; sends WordA and checks the N-cycle latency.
    task automatic check_aligned_word(input string tag);
        in_valid = 1'b1;
        in_data  = WordA;
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            if (k < 8) begin
                total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL %s_valid k=%0d got %h want 00", tag, k, out_valid); end
                total++; if (out_data !== 64'h0) begin bad++; $display("FAIL %s_data k=%0d got %h want 0", tag, k, out_data); end
            end else begin
                total++; if (out_valid !== 8'hFF) begin bad++; $display("FAIL %s_valid k=8 got %h want ff", tag, out_valid); end
                total++; if (out_data !== WordA) begin bad++; $display("FAIL %s_data k=8 got %h want %h", tag, out_data, WordA); end
            end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy k=%0d got %b want 1", tag, k, busy); end
        end
        tick();
        total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL %s_drain got %b want 1", tag, drain_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got %b want 0", tag, busy); end
    endtask

    task automatic test_aligned;
        skew_en = 1'b0;
        tick();
        check_aligned_word("aligned");
        skew_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_back_to_back(input bit toggle, input string tag);
        logic [7:0]  ev;
        logic [63:0] ed;
        int          w;
        int          pulses;
        pulses = 0;
        for (int k = 1; k <= 21; k++) begin
            if (k <= 12) begin
                in_valid = 1'b1;
                in_data  = rep(8'(k - 1));
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            if (toggle && k == 5) skew_en = 1'b0;
            tick();
            ev = '0;
            ed = '0;
            for (int i = 0; i < N; i++) begin
                w = k - 1 - i;
                if (w >= 0 && w <= 11) begin
                    ev[i]         = 1'b1;
                    ed[i*8 +: 8]  = 8'(w);
                end
            end
            if (drain_done === 1'b1) pulses++;
            total++; if (out_valid !== ev) begin bad++; $display("FAIL %s_valid k=%0d got %h want %h", tag, k, out_valid, ev); end
            total++; if (out_data !== ed) begin bad++; $display("FAIL %s_data k=%0d got %h want %h", tag, k, out_data, ed); end
            total++; if (busy !== (k <= 19)) begin bad++; $display("FAIL %s_busy k=%0d got %b want %b", tag, k, busy, (k <= 19)); end
            total++; if (drain_done !== (k == 20)) begin bad++; $display("FAIL %s_drain k=%0d got %b want %b", tag, k, drain_done, (k == 20)); end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL %s_pulses got %0d want 1", tag, pulses); end
        if (toggle) begin
            check_aligned_word({tag, "_after"});
            skew_en = 1'b1;
            tick();
            tick();
        end
    endtask

    task automatic test_bubble;
        logic [7:0]  ev;
        logic [63:0] ed;
        int          t;
        for (int k = 1; k <= 11; k++) begin
            in_valid = (k == 1 || k == 3);
            in_data  = (k == 1) ? rep(8'hA5) : (k == 2) ? rep(8'hFF) : (k == 3) ? rep(8'h3C) : '0;
            tick();
            ev = '0;
            ed = '0;
            for (int i = 0; i < N; i++) begin
                t = k - i;
                if (t == 1) begin ev[i] = 1'b1; ed[i*8 +: 8] = 8'hA5; end
                if (t == 3) begin ev[i] = 1'b1; ed[i*8 +: 8] = 8'h3C; end
            end
            total++; if (out_valid !== ev) begin bad++; $display("FAIL bubble_valid k=%0d got %h want %h", k, out_valid, ev); end
            total++; if (out_data !== ed) begin bad++; $display("FAIL bubble_data k=%0d got %h want %h", k, out_data, ed); end
            total++; if (drain_done !== (k == 11)) begin bad++; $display("FAIL bubble_drain k=%0d got %b want %b", k, drain_done, (k == 11)); end
        end
        tick();
    endtask

    task automatic test_flush;
        int pulses;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = rep(8'(k + 1));
            tick();
        end
        total++; if (out_valid !== 8'h07) begin bad++; $display("FAIL flush_pre_valid got %h want 07", out_valid); end
        in_data = rep(8'h04);
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL flush_valid got %h want 00", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL flush_data got %h want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got %b want 0", busy); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL flush_drain got %b want 0", drain_done); end
        in_data = rep(8'h05);
        tick();
        total++; if (out_valid !== 8'h01) begin bad++; $display("FAIL flush_w4_valid got %h want 01", out_valid); end
        total++; if (out_data !== 64'h05) begin bad++; $display("FAIL flush_w4_data got %h want 05", out_data); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL flush_w4_drain got %b want 0", drain_done); end
        in_data = rep(8'h06);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        total++; if (out_data !== 64'h0506) begin bad++; $display("FAIL flush_w5_data got %h want 0506", out_data); end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (drain_done === 1'b1) pulses++;
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL flush_tail_pulses got %0d want 1", pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_tail_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midstream;
        logic [7:0]  ev;
        logic [63:0] ed;
        skew_en = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = rep(8'(k + 16));
            tick();
        end
        total++; if (out_valid !== 8'hFF) begin bad++; $display("FAIL rstmid_pre_valid got %h want ff", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL rstmid_valid got %h want 00", out_valid); end
        total++; if (out_data !== 64'h0) begin bad++; $display("FAIL rstmid_data got %h want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL rstmid_drain got %b want 0", drain_done); end
        tick();
        @(negedge clk);
        rst_n    = 1'b1;
        // skew_en still 0: a word in the first cycle keeps mode_q at its reset value.
        in_valid = 1'b1;
        in_data  = WordA;
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            ev = 8'(1 << (k - 1));
            ed = WordA & (64'hFF << ((k - 1) * 8));
            total++; if (out_valid !== ev) begin bad++; $display("FAIL rstmid_skew_valid k=%0d got %h want %h", k, out_valid, ev); end
            total++; if (out_data !== ed) begin bad++; $display("FAIL rstmid_skew_data k=%0d got %h want %h", k, out_data, ed); end
        end
        tick();
        total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL rstmid_drain_pulse got %b want 1", drain_done); end
        skew_en = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_skew_single();
        test_aligned();
        test_back_to_back(1'b0, "b2b");
        test_back_to_back(1'b1, "toggle");
        test_bubble();
        test_flush();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
